uart_tx_arbiter: RTL

Shares one UART transmit line among NUM_REQ byte requesters, making it the transmit-side counterpart of the `rx` receiver. Each requester offers a byte with a valid/ready handshake. A round-robin arbiter grants one requester per frame and serializes the byte as 8N1: start bit, 8 data bits LSB first, one stop bit. The block sits between on-chip byte sources (command responders, status reporters) and the board `tx` pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 21 ++
 rtl/uart_tx_serializer.sv | 125 ++++++++++++
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Purpose: state encoding and frame constants used by the UART tx and rx blocks.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_CLKS_PER_BIT = 1250;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte handshake bundle
// Purpose: groups the per-requester valid/data/ready signals of the tx arbiter.
// Ports (signals):
//   req_valid[NUM_REQ]     requester i offers a byte
//   req_data[8*NUM_REQ]    byte i at [8*i +: 8]
//   req_ready[NUM_REQ]     one-hot or zero accept strobe from the arbiter
// Modports: master = requesters, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 frame serializer
// Purpose: turns one accepted byte into start, 8 data bits LSB first, stop.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   start  accept strobe; sampled only while idle
//   data   byte captured on the accept edge
//   tx     registered serial line, idle high
//   busy   registered, high from the cycle after accept until back in IDLE
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      tx,
  output logic                      busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // tx_d/busy_d are computed from the state being entered, so the line
  // changes on the same edge as the state and the outputs stay registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            // Next bit is shift_q[1]: the shifted value is not visible yet.
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART tx line
// Purpose: grants one of NUM_REQ byte requesters per frame and serializes it 8N1.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-low
//   req_if    slave side of the requester handshake (valid/data in, ready out)
//   tx        serial line, idle high
//   busy      high from the cycle after accept until the frame ends
//   grant_id  requester owning the current or last frame
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int NUM_REQ      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           req_if,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]           last_grant_q, last_grant_d;
  logic [ID_W-1:0]           grant_id_q, grant_id_d;
  logic [ID_W-1:0]           winner;
  logic [ID_W-1:0]           idx;
  int                        sum;
  logic                      found;
  logic                      accept;
  logic                      ser_busy;
  logic [UART_DATA_BITS-1:0] win_data;

  // Search starts just after the last winner and wraps, so the previous
  // owner is considered last.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    idx    = '0;
    sum    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_grant_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!found && req_if.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = req_if.req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
    end
  end

  // The serializer's busy is low exactly while it sits in IDLE.
  assign accept = found && !ser_busy;

  always_comb begin
    req_if.req_ready = '0;
    if (accept) req_if.req_ready[winner] = 1'b1;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    if (accept) begin
      last_grant_d = winner;
      grant_id_d   = winner;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clock(clock),
    .reset(reset),
    .start(accept),
    .data (win_data),
    .tx   (tx),
    .busy (ser_busy)
  );

  assign busy     = ser_busy;
  assign grant_id = grant_id_q;

endmodule
